// File: rtl/fir_dvs_sequencer_if.sv
// Handshake/status bundle for the FIR DVS sequencer.
// Optional force ports appear when FIR_DVS_FORCE_EN is defined.
interface fir_dvs_sequencer_if;
  logic       in_tvalid;
  logic       in_tready;
  logic       vreg_ack;
  logic       vreg_req;
  logic [1:0] vreg_target;
  logic [1:0] perf_level;
  logic [1:0] clk_div_sel;
  logic       fir_hold;
  logic       busy;
  logic       fault;
`ifdef FIR_DVS_FORCE_EN
  logic       force_en;
  logic [1:0] force_level;
`endif

  modport master (
    output in_tvalid,
    output in_tready,
    output vreg_ack,
`ifdef FIR_DVS_FORCE_EN
    output force_en,
    output force_level,
`endif
    input  vreg_req,
    input  vreg_target,
    input  perf_level,
    input  clk_div_sel,
    input  fir_hold,
    input  busy,
    input  fault
  );

  modport slave (
    input  in_tvalid,
    input  in_tready,
    input  vreg_ack,
`ifdef FIR_DVS_FORCE_EN
    input  force_en,
    input  force_level,
`endif
    output vreg_req,
    output vreg_target,
    output perf_level,
    output clk_div_sel,
    output fir_hold,
    output busy,
    output fault
  );
endinterface

// File: rtl/fir_dvs_sequencer.sv
// Load-driven DVS sequencer: voltage-then-clock up, clock-then-voltage down.
// FIR_DVS_FORCE_EN adds a forced target level in place of load thresholds.
module fir_dvs_sequencer #(
  parameter int WINDOW_LOG2   = 6,
  parameter int HI_THRESH     = 48,
  parameter int LO_THRESH     = 16,
  parameter int SETTLE_CYCLES = 32,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_dvs_sequencer_if.slave   bus
);

  localparam int BW   = WINDOW_LOG2 + 1;
  localparam int TMAX = (ACK_TIMEOUT > SETTLE_CYCLES) ?
                        ACK_TIMEOUT : SETTLE_CYCLES;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [WINDOW_LOG2-1:0] W1 = 1;
  localparam logic [CW-1:0]          C1 = 1;

  typedef enum logic [2:0] {
    MONITOR,
    UP_VREQ,
    UP_SETTLE,
    UP_SWITCH,
    DN_HOLD,
    DN_VREQ,
    FAULT
  } state_t;

  state_t state, state_n;

  logic [WINDOW_LOG2-1:0] wcnt;
  logic [BW-1:0]          bcnt;
  logic [BW-1:0]          beats;
  logic [CW-1:0]          cnt;
  logic [1:0]             perf;
  logic [1:0]             vtgt;
  logic [1:0]             vack;

  logic beat, last, ack, tmo;
  logic go_up, go_dn;
  logic up_go, dn_req, to_fault;

  assign beat  = bus.in_tvalid & bus.in_tready;
  assign last  = &wcnt;
  assign beats = bcnt + BW'(beat);
  assign ack   = bus.vreg_ack;
  assign tmo   = (cnt == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    go_up = (beats >= BW'(HI_THRESH)) &&
            (perf != 2'd3);
    go_dn = (beats <= BW'(LO_THRESH)) &&
            (perf != 2'd0);
`ifdef FIR_DVS_FORCE_EN
    if (bus.force_en) begin
      go_up = bus.force_level > perf;
      go_dn = bus.force_level < perf;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MONITOR;
    else       state <= state_n;
  end

  // Ack is checked before timeout so a same-cycle ack wins.
  always_comb begin
    state_n = state;
    unique case (state)
      MONITOR:
        if (last) begin
          if (go_up)      state_n = UP_VREQ;
          else if (go_dn) state_n = DN_HOLD;
        end
      UP_VREQ:
        if (ack)      state_n = UP_SETTLE;
        else if (tmo) state_n = FAULT;
      UP_SETTLE:
        if (cnt == CW'(SETTLE_CYCLES - 1))
          state_n = UP_SWITCH;
      UP_SWITCH:
        if (cnt == C1) state_n = MONITOR;
      DN_HOLD:
        if (cnt == C1) state_n = DN_VREQ;
      DN_VREQ:
        if (ack)      state_n = MONITOR;
        else if (tmo) state_n = FAULT;
      FAULT:   state_n = FAULT;
      default: state_n = MONITOR;
    endcase
  end

  // Window state is held at zero outside MONITOR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      bcnt <= '0;
    end else if (state == MONITOR && !last) begin
      wcnt <= wcnt + W1;
      bcnt <= beats;
    end else begin
      wcnt <= '0;
      bcnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state_n != state ||
             state == MONITOR ||
             state == FAULT)
      cnt <= '0;
    else
      cnt <= cnt + C1;
  end

  assign up_go    = (state == MONITOR) &&
                    (state_n == UP_VREQ);
  assign dn_req   = (state == DN_HOLD) &&
                    (state_n == DN_VREQ);
  assign to_fault = (state != FAULT) &&
                    (state_n == FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vtgt <= 2'd0;
      vack <= 2'd0;
      perf <= 2'd0;
    end else begin
      unique case (1'b1)
        up_go:    vtgt <= perf + 2'd1;
        dn_req:   vtgt <= perf;
        to_fault: vtgt <= vack;
        default:  ;
      endcase
      if ((state == UP_VREQ || state == DN_VREQ) && ack)
        vack <= vtgt;
      if (state == UP_SETTLE && state_n == UP_SWITCH)
        perf <= perf + 2'd1;
      if (state == MONITOR && state_n == DN_HOLD)
        perf <= perf - 2'd1;
    end
  end

  assign bus.vreg_req    = (state == UP_VREQ) ||
                           (state == DN_VREQ);
  assign bus.vreg_target = vtgt;
  assign bus.perf_level  = perf;
  assign bus.clk_div_sel = 2'd3 - perf;
  assign bus.fir_hold    = (state == UP_SWITCH) ||
                           (state == DN_HOLD);
  assign bus.busy        = (state != MONITOR);
  assign bus.fault       = (state == FAULT);

endmodule

// File: tb/tb_fir_dvs_sequencer.sv
// Scoreboard bench for fir_dvs_sequencer: timeline model feeds expected
// events; a negedge monitor pops them. Force test under FIR_DVS_FORCE_EN.
module tb_fir_dvs_sequencer;

  typedef enum int {EV_REQ, EV_HOLD, EV_IDLE, EV_FAULT} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       lvl;
    int       tgt;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fir_dvs_sequencer_if bus();

  fir_dvs_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  ev_t expq[$];

  int m_lvl  = 0;
  int m_volt = 0;
  int load      = 0;
  int ack_delay = 3;
  bit spur_en   = 1'b1;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  function automatic void push(ev_kind_t k, int c, int l, int v);
    ev_t e;
    e.kind = k; e.cyc = c; e.lvl = l; e.tgt = v;
    expq.push_back(e);
  endfunction

  task automatic chk(string name, int got, int want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- reference model (timeline of the rules) ----------------
  task automatic m_wait(input int n, output bit rs, output int t);
    rs = 1'b0; t = 0;
    repeat (n) begin
      @(posedge clk);
      if (reset) begin rs = 1'b1; return; end
      t = cyc;
    end
  endtask

  task automatic m_ack(output bit ok, output bit rs, output int t);
    ok = 1'b0; rs = 1'b0; t = 0;
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk);
      if (reset) begin rs = 1'b1; return; end
      t = cyc;
      if (bus.vreg_ack) begin ok = 1'b1; return; end
    end
  endtask

  task automatic model_run();
    bit rs, ok, up, dn;
    int t, c;
    m_lvl = 0; m_volt = 0; t = 0;
    forever begin
      c = 0;
      for (int i = 0; i < 64; i++) begin
        @(posedge clk);
        if (reset) return;
        t = cyc;
        if (bus.in_tvalid && bus.in_tready) c++;
      end
      up = (c >= 48) && (m_lvl < 3);
      dn = (c <= 16) && (m_lvl > 0);
`ifdef FIR_DVS_FORCE_EN
      if (bus.force_en) begin
        up = int'(bus.force_level) > m_lvl;
        dn = int'(bus.force_level) < m_lvl;
      end
`endif
      if (up) begin
        push(EV_REQ, t + 1, m_lvl, m_lvl + 1);
        m_ack(ok, rs, t);
        if (rs) return;
        if (!ok) begin
          push(EV_FAULT, t + 1, m_lvl, m_volt);
          return;
        end
        m_volt = m_lvl + 1;
        m_wait(32, rs, t);
        if (rs) return;
        m_lvl++;
        push(EV_HOLD, t + 1, m_lvl, m_volt);
        m_wait(2, rs, t);
        if (rs) return;
        push(EV_IDLE, t + 1, m_lvl, m_volt);
      end else if (dn) begin
        m_lvl--;
        push(EV_HOLD, t + 1, m_lvl, m_volt);
        m_wait(2, rs, t);
        if (rs) return;
        push(EV_REQ, t + 1, m_lvl, m_lvl);
        m_ack(ok, rs, t);
        if (rs) return;
        if (!ok) begin
          push(EV_FAULT, t + 1, m_lvl, m_volt);
          return;
        end
        m_volt = m_lvl;
        push(EV_IDLE, t + 1, m_lvl, m_volt);
      end
    end
  endtask

  initial forever begin
    @(negedge reset);
    model_run();
  end

  // ---------------- stimulus drivers ----------------
  initial begin
    bus.in_tvalid = 1'b0;
    bus.in_tready = 1'b0;
    forever begin
      @(negedge clk);
      case (load)
        0: begin
          bus.in_tvalid = 1'b0;
          bus.in_tready = 1'($urandom_range(0, 1));
        end
        1: begin
          bus.in_tvalid = 1'b1;
          bus.in_tready = 1'b1;
        end
        2: begin
          bus.in_tvalid = 1'($urandom_range(0, 1));
          bus.in_tready = 1'b1;
        end
        default: begin
          bus.in_tvalid = ($urandom_range(0, 3) == 0);
          bus.in_tready = ($urandom_range(0, 3) == 0);
        end
      endcase
    end
  end

  // Regulator: ack after a delay; stray acks while no request.
  initial begin
    int age, cur;
    age = 0; cur = 0;
    bus.vreg_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.vreg_ack = 1'b0;
      if (reset) age = 0;
      else if (bus.vreg_req) begin
        if (age == 0)
          cur = (ack_delay < 0) ? int'($urandom_range(0, 40))
                                : ack_delay;
        if (age == cur) bus.vreg_ack = 1'b1;
        age++;
      end else begin
        age = 0;
        if (spur_en && $urandom_range(0, 7) == 0)
          bus.vreg_ack = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic check_ev(ev_kind_t k);
    ev_t e;
    bit bad;
    vectors++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got cyc=%0d lvl=%0d tgt=%0d, want none",
               k.name(), cyc, bus.perf_level, bus.vreg_target);
      return;
    end
    e = expq.pop_front();
    bad = (e.kind != k) || (e.cyc != cyc) ||
          (int'(bus.perf_level) != e.lvl) ||
          (int'(bus.clk_div_sel) != 3 - e.lvl) ||
          (int'(bus.vreg_target) != e.tgt) ||
          (bus.busy != (k != EV_IDLE)) ||
          (k == EV_FAULT && (bus.vreg_req || bus.fir_hold));
    if (bad) begin
      errors++;
      $display("FAIL event_%s: got cyc=%0d lvl=%0d div=%0d tgt=%0d busy=%0b req=%0b hold=%0b, want %s cyc=%0d lvl=%0d div=%0d tgt=%0d",
               k.name(), cyc, bus.perf_level, bus.clk_div_sel,
               bus.vreg_target, bus.busy, bus.vreg_req, bus.fir_hold,
               e.kind.name(), e.cyc, e.lvl, 3 - e.lvl, e.tgt);
    end
  endtask

  bit req_q, hold_q, busy_q, fault_q;
  int hold_len;

  always @(negedge clk) begin
    if (reset) begin
      req_q = 0; hold_q = 0; busy_q = 0; fault_q = 0;
      hold_len = 0;
    end else begin
      if (bus.vreg_req && !req_q)   check_ev(EV_REQ);
      if (bus.fir_hold && !hold_q)  check_ev(EV_HOLD);
      if (!bus.busy && busy_q)      check_ev(EV_IDLE);
      if (bus.fault && !fault_q)    check_ev(EV_FAULT);
      if (bus.fir_hold) hold_len++;
      else if (hold_q) begin
        chk("hold_len", hold_len, 2);
        hold_len = 0;
      end
      req_q   = bus.vreg_req;
      hold_q  = bus.fir_hold;
      busy_q  = bus.busy;
      fault_q = bus.fault;
    end
  end

  // ---------------- test sequence ----------------
  task automatic chk_reset_vals(string tag);
    chk({tag, "_perf"},  int'(bus.perf_level), 0);
    chk({tag, "_tgt"},   int'(bus.vreg_target), 0);
    chk({tag, "_div"},   int'(bus.clk_div_sel), 3);
    chk({tag, "_req"},   int'(bus.vreg_req), 0);
    chk({tag, "_hold"},  int'(bus.fir_hold), 0);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_fault"}, int'(bus.fault), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    expq.delete();
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
`ifdef FIR_DVS_FORCE_EN
    bus.force_en = 1'b0;
    bus.force_level = 2'd0;
`endif
    do_reset();

    // Full load, ack after 3: climb to level 3 and stay.
    load = 1; ack_delay = 3;
    run(700);
    chk("t1_perf", int'(bus.perf_level), 3);
    chk("t1_div",  int'(bus.clk_div_sel), 0);
    chk("t1_tgt",  int'(bus.vreg_target), 3);
    chk("t1_busy", int'(bus.busy), 0);

    // Light load walks down to level 1, then mid load holds it.
    load = 3; ack_delay = -1;
    n = 0;
    while (m_lvl != 1 && n < 1500) begin
      @(negedge clk); n++;
    end
    chk("t2_timeout", int'(n < 1500), 1);
    load = 2;
    run(600);
    chk("t3_perf", int'(bus.perf_level), 1);
    chk("t3_div",  int'(bus.clk_div_sel), 2);
    chk("t3_tgt",  int'(bus.vreg_target), 1);
    chk("t3_req",  int'(bus.vreg_req), 0);

    // Regulator never answers: sticky fault.
    do_reset();
    load = 1; ack_delay = 1000;
    run(400);
    chk("t4_fault", int'(bus.fault), 1);
    chk("t4_req",   int'(bus.vreg_req), 0);
    chk("t4_tgt",   int'(bus.vreg_target), 0);
    chk("t4_perf",  int'(bus.perf_level), 0);
    chk("t4_div",   int'(bus.clk_div_sel), 3);
    chk("t4_busy",  int'(bus.busy), 1);
    chk("t4_hold",  int'(bus.fir_hold), 0);

    // Ack on the last legal request cycle, then reset mid-settle.
    do_reset();
    load = 1; ack_delay = 254;
    n = 0;
    while (!bus.vreg_req && n < 600) begin
      @(negedge clk); n++;
    end
    chk("t5_req_seen", int'(bus.vreg_req), 1);
    n = 0;
    while (bus.vreg_req && n < 300) begin
      @(negedge clk); n++;
    end
    chk("t5_req_len", n, 255);
    run(10);
    chk("t5_fault", int'(bus.fault), 0);
    chk("t5_busy",  int'(bus.busy), 1);
    chk("t5_tgt",   int'(bus.vreg_target), 1);
    chk("t5_perf",  int'(bus.perf_level), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    expq.delete();
    #1 chk_reset_vals("t5_async");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Random loads and ack delays.
    ack_delay = -1;
    repeat (20) begin
      load = int'($urandom_range(0, 3));
      run(int'($urandom_range(40, 200)));
    end
    load = 2;
    run(400);

`ifdef FIR_DVS_FORCE_EN
    do_reset();
    load = 0; ack_delay = 3;
    bus.force_en = 1'b1;
    bus.force_level = 2'd2;
    run(700);
    chk("t6_perf", int'(bus.perf_level), 2);
    chk("t6_div",  int'(bus.clk_div_sel), 1);
    chk("t6_busy", int'(bus.busy), 0);
`endif

    chk("pending_events", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
